// File: rtl/m68k_bus_target.sv
// m68k_bus_target: decodes 68000 bus cycles in a fixed window and forwards each hit to a backend.
// Latency: 2-cycle strobe sync + 1 decode cycle; DTACK no earlier than WAIT_CYCLES after decode.
// Backpressure: be_req held until be_ack; BERR after TIMEOUT_CYCLES cycles of be_req without ack.
//
// Ports:
//   sys_clk, sys_rst_n         clock, synchronous active-low reset
//   A_IN, D_IN, FC_IN, RnW_IN  68k address [23:1], data in, function code, read/not-write
//   nAS_IN, nUDS_IN, nLDS_IN   68k strobes (active low, asynchronous to sys_clk)
//   D_OUT, D_OE                read data and its bus drive enable
//   nDTACK_OE, nBERR_OE        1 = pull the corresponding open-drain line low
//   be_req .. be_wdata         backend request and its command fields
//   be_rdata, be_ack           backend read data and completion pulse
//   busy, berr_count           FSM not idle; saturating count of bus errors
module m68k_bus_target #(
  parameter logic [23:0] BASE_ADDR      = 24'hEF0000,
  parameter logic [23:0] ADDR_MASK      = 24'hFF0000,
  parameter int unsigned WAIT_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [23:1] A_IN,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic [2:0]  FC_IN,
  input  logic        RnW_IN,
  input  logic        nAS_IN,
  input  logic        nUDS_IN,
  input  logic        nLDS_IN,
  output logic        nDTACK_OE,
  output logic        nBERR_OE,
  output logic        be_req,
  output logic        be_we,
  output logic [23:1] be_addr,
  output logic [1:0]  be_be,
  output logic [15:0] be_wdata,
  input  logic [15:0] be_rdata,
  input  logic        be_ack,
  output logic        busy,
  output logic [7:0]  berr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_BACKEND,
    S_HOLD,
    S_TERM,
    S_RELEASE
  } state_e;

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);
  // The timeout counter is 0 in the first be_req cycle, so this value marks the last allowed cycle.
  localparam logic [9:0] TO_LAST  = 10'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  nas_sync_q, uds_sync_q, lds_sync_q, rnw_sync_q;
  logic        nas_s, uds_s, lds_s, rnw_s;

  logic        be_req_q, be_req_d;
  logic        be_we_q, be_we_d;
  logic [23:1] be_addr_q, be_addr_d;
  logic [1:0]  be_be_q, be_be_d;
  logic [15:0] be_wdata_q, be_wdata_d;
  logic [15:0] d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        dtack_q, dtack_d;
  logic        berr_q, berr_d;
  logic [7:0]  berr_cnt_q, berr_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [9:0]  to_cnt_q, to_cnt_d;
  logic        abort_q, abort_d;

  logic        hit;
  logic        aborting;

  assign nas_s = nas_sync_q[1];
  assign uds_s = uds_sync_q[1];
  assign lds_s = lds_sync_q[1];
  assign rnw_s = rnw_sync_q[1];

  // Address/FC are sampled raw: by the time the synced strobes are low they have long settled.
  assign hit = ((({A_IN, 1'b0}) & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) && (FC_IN != 3'b111);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      nas_sync_q <= 2'b11;
      uds_sync_q <= 2'b11;
      lds_sync_q <= 2'b11;
      rnw_sync_q <= 2'b11;
      state_q    <= S_IDLE;
      be_req_q   <= 1'b0;
      be_we_q    <= 1'b0;
      be_addr_q  <= '0;
      be_be_q    <= '0;
      be_wdata_q <= '0;
      d_out_q    <= '0;
      d_oe_q     <= 1'b0;
      dtack_q    <= 1'b0;
      berr_q     <= 1'b0;
      berr_cnt_q <= '0;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      abort_q    <= 1'b0;
    end else begin
      nas_sync_q <= {nas_sync_q[0], nAS_IN};
      uds_sync_q <= {uds_sync_q[0], nUDS_IN};
      lds_sync_q <= {lds_sync_q[0], nLDS_IN};
      rnw_sync_q <= {rnw_sync_q[0], RnW_IN};
      state_q    <= state_d;
      be_req_q   <= be_req_d;
      be_we_q    <= be_we_d;
      be_addr_q  <= be_addr_d;
      be_be_q    <= be_be_d;
      be_wdata_q <= be_wdata_d;
      d_out_q    <= d_out_d;
      d_oe_q     <= d_oe_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
      berr_cnt_q <= berr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    be_req_d   = be_req_q;
    be_we_d    = be_we_q;
    be_addr_d  = be_addr_q;
    be_be_d    = be_be_q;
    be_wdata_d = be_wdata_q;
    d_out_d    = d_out_q;
    d_oe_d     = d_oe_q;
    dtack_d    = dtack_q;
    berr_d     = berr_q;
    berr_cnt_d = berr_cnt_q;
    to_cnt_d   = to_cnt_q;
    abort_d    = abort_q;
    aborting   = abort_q | nas_s;
    // Saturating so a long backend stall cannot wrap it back under WAIT_LIM.
    wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;

    unique case (state_q)
      S_IDLE: begin
        if (!nas_s && (!uds_s || !lds_s)) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (hit) begin
          be_req_d   = 1'b1;
          be_we_d    = ~rnw_s;
          be_addr_d  = A_IN;
          be_be_d    = {~uds_s, ~lds_s};
          be_wdata_d = D_IN;
          wait_cnt_d = 4'd1;
          to_cnt_d   = '0;
          abort_d    = 1'b0;
          state_d    = S_BACKEND;
        end else begin
          state_d = S_RELEASE;
        end
      end

      S_BACKEND: begin
        to_cnt_d = to_cnt_q + 10'd1;
        abort_d  = aborting;
        // Ack is tested first so an ack in the final allowed cycle beats the timeout.
        if (be_ack) begin
          be_req_d = 1'b0;
          if (aborting) begin
            state_d = S_RELEASE;
          end else begin
            if (!be_we_q) begin
              d_out_d = be_rdata;
              d_oe_d  = 1'b1;
            end
            state_d = S_HOLD;
          end
        end else if (to_cnt_q == TO_LAST) begin
          be_req_d = 1'b0;
          if (aborting) begin
            state_d = S_RELEASE;
          end else begin
            berr_d     = 1'b1;
            berr_cnt_d = (berr_cnt_q == 8'hFF) ? berr_cnt_q : berr_cnt_q + 8'd1;
            state_d    = S_TERM;
          end
        end
      end

      S_HOLD: begin
        if (wait_cnt_q >= WAIT_LIM) begin
          dtack_d = 1'b1;
          state_d = S_TERM;
        end
      end

      S_TERM: begin
        // Strobes-high also ends the cycle so a TAS read phase (nAS held low) can terminate.
        if (nas_s || (uds_s && lds_s)) begin
          dtack_d = 1'b0;
          berr_d  = 1'b0;
          d_oe_d  = 1'b0;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        // Waiting for strobes high stops the same strobe from retriggering; with nAS still low
        // the next strobe of a read-modify-write is then decoded as a fresh transaction.
        if (uds_s && lds_s) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign D_OUT      = d_out_q;
  assign D_OE       = d_oe_q;
  assign nDTACK_OE  = dtack_q;
  assign nBERR_OE   = berr_q;
  assign be_req     = be_req_q;
  assign be_we      = be_we_q;
  assign be_addr    = be_addr_q;
  assign be_be      = be_be_q;
  assign be_wdata   = be_wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign berr_count = berr_cnt_q;

endmodule
